// File: rtl/axi_4kb_burst_splitter_if.sv
`default_nettype none
// ============================================================================
// axi_4kb_burst_splitter_if : request/sub-burst command bus of the splitter
// Revision 1.0
// ============================================================================
interface axi_4kb_burst_splitter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int SIZE_WIDTH = 3
) ();
  logic [ADDR_WIDTH-1:0] s_addr_i;
  logic [LEN_WIDTH-1:0]  s_len_i;
  logic [SIZE_WIDTH-1:0] s_size_i;
  logic                  s_valid_i;
  logic                  s_ready_o;
  logic [ADDR_WIDTH-1:0] m_addr_o;
  logic [LEN_WIDTH-1:0]  m_len_o;
  logic [SIZE_WIDTH-1:0] m_size_o;
  logic                  m_last_o;
  logic                  m_valid_o;
  logic                  m_ready_i;

  modport slave (
    input  s_addr_i, s_len_i, s_size_i, s_valid_i, m_ready_i,
    output s_ready_o, m_addr_o, m_len_o, m_size_o, m_last_o, m_valid_o
  );

  modport master (
    output s_addr_i, s_len_i, s_size_i, s_valid_i, m_ready_i,
    input  s_ready_o, m_addr_o, m_len_o, m_size_o, m_last_o, m_valid_o
  );
endinterface
`default_nettype wire

// File: rtl/axi_4kb_burst_splitter.sv
`default_nettype none
// ============================================================================
// axi_4kb_burst_splitter : cuts INCR AW/AR bursts at 2^BOUNDARY_BITS borders
// Revision 1.0
// ============================================================================
module axi_4kb_burst_splitter #(
  parameter int ADDR_WIDTH    = 32,
  parameter int LEN_WIDTH     = 8,
  parameter int SIZE_WIDTH    = 3,
  parameter int BOUNDARY_BITS = 12
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,
  axi_4kb_burst_splitter_if.slave   bus,
  output logic                      busy_o
);
  localparam int CW = (LEN_WIDTH + 1 > BOUNDARY_BITS + 1) ? LEN_WIDTH + 1 : BOUNDARY_BITS + 1;
  localparam int UW = ADDR_WIDTH - BOUNDARY_BITS;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SPLIT = 1'b1} state_t;

  state_t                r_state, w_state_nxt;
  logic [LEN_WIDTH:0]    r_rem, w_rem_nxt;
  logic [ADDR_WIDTH-1:0] r_m_addr, w_addr_nxt;
  logic [LEN_WIDTH-1:0]  r_m_len, w_len_nxt;
  logic [SIZE_WIDTH-1:0] r_m_size, w_size_nxt;
  logic                  r_m_last, w_last_nxt;
  logic                  r_m_valid, w_valid_nxt;

  logic                  w_hs;
  logic [LEN_WIDTH:0]    w_rem_after;
  logic [ADDR_WIDTH-1:0] w_addr_after;
  logic [ADDR_WIDTH-1:0] w_src_addr;
  logic [LEN_WIDTH:0]    w_src_rem;
  logic [SIZE_WIDTH-1:0] w_src_size;
  logic [BOUNDARY_BITS-1:0] w_base;
  logic [BOUNDARY_BITS:0]   w_btb;
  logic [CW-1:0]         w_btb_x, w_rem_x;
  logic [LEN_WIDTH:0]    w_chunk;
  logic [LEN_WIDTH-1:0]  w_piece_len;
  logic                  w_piece_last;

  assign w_hs = r_m_valid & bus.m_ready_i;

  // The output register always holds the current piece, so it doubles as the
  // running address; the next piece always starts on the following boundary.
  assign w_rem_after  = r_rem - ((LEN_WIDTH + 1)'(r_m_len) + (LEN_WIDTH + 1)'(1));
  assign w_addr_after = {r_m_addr[ADDR_WIDTH-1:BOUNDARY_BITS] + UW'(1), {BOUNDARY_BITS{1'b0}}};

  assign w_src_addr = (r_state == ST_IDLE) ? bus.s_addr_i : w_addr_after;
  assign w_src_rem  = (r_state == ST_IDLE) ? ((LEN_WIDTH + 1)'(bus.s_len_i) + (LEN_WIDTH + 1)'(1))
                                           : w_rem_after;
  assign w_src_size = (r_state == ST_IDLE) ? bus.s_size_i : r_m_size;

  assign w_base  = w_src_addr[BOUNDARY_BITS-1:0] & ({BOUNDARY_BITS{1'b0}} | ({BOUNDARY_BITS{1'b1}} << w_src_size));
  assign w_btb   = ({1'b1, {BOUNDARY_BITS{1'b0}}} - {1'b0, w_base}) >> w_src_size;
  assign w_btb_x = CW'(w_btb);
  assign w_rem_x = CW'(w_src_rem);
  assign w_chunk = (w_rem_x <= w_btb_x) ? w_src_rem : w_btb_x[LEN_WIDTH:0];
  assign w_piece_len  = LEN_WIDTH'(w_chunk - (LEN_WIDTH + 1)'(1));
  assign w_piece_last = (w_chunk == w_src_rem);

  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_addr_nxt  = r_m_addr;
    w_len_nxt   = r_m_len;
    w_size_nxt  = r_m_size;
    w_last_nxt  = r_m_last;
    w_valid_nxt = r_m_valid;
    case (r_state)
      ST_IDLE: begin
        if (bus.s_valid_i) begin
          w_state_nxt = ST_SPLIT;
          w_rem_nxt   = w_src_rem;
          w_addr_nxt  = w_src_addr;
          w_len_nxt   = w_piece_len;
          w_size_nxt  = w_src_size;
          w_last_nxt  = w_piece_last;
          w_valid_nxt = 1'b1;
        end
      end
      ST_SPLIT: begin
        if (w_hs) begin
          w_rem_nxt = w_rem_after;
          if (r_m_last) begin
            w_state_nxt = ST_IDLE;
            w_valid_nxt = 1'b0;
          end else begin
            w_addr_nxt  = w_src_addr;
            w_len_nxt   = w_piece_len;
            w_last_nxt  = w_piece_last;
            w_valid_nxt = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state   <= ST_IDLE;
      r_rem     <= '0;
      r_m_addr  <= '0;
      r_m_len   <= '0;
      r_m_size  <= '0;
      r_m_last  <= 1'b0;
      r_m_valid <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rem     <= w_rem_nxt;
      r_m_addr  <= w_addr_nxt;
      r_m_len   <= w_len_nxt;
      r_m_size  <= w_size_nxt;
      r_m_last  <= w_last_nxt;
      r_m_valid <= w_valid_nxt;
    end
  end

  assign bus.s_ready_o = (r_state == ST_IDLE);
  assign bus.m_addr_o  = r_m_addr;
  assign bus.m_len_o   = r_m_len;
  assign bus.m_size_o  = r_m_size;
  assign bus.m_last_o  = r_m_last;
  assign bus.m_valid_o = r_m_valid;
  assign busy_o        = (r_state == ST_SPLIT);
endmodule
`default_nettype wire
